instr_fetch_unit: RTL and testbench

- Downstream consumer of the 8x11-bit register-file RAM (RAM_MxNbit) in the 5-bit CPU.
- Holds the program counter, drives the RAM read address, and captures the 11-bit word (7-bit opcode, 4-bit operand) into an instruction register.
- Presents the captured word to decode through a valid/ready handshake.
- Handles start, branch redirect and halt-opcode detection.

---
 rtl/cpu5_pkg.sv | 22 ++
 rtl/RAM_MxNbit.sv | 29 ++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu5_pkg.sv
// Shared constants, fetch FSM state type and opcode-field helper
// for the 5-bit CPU fetch path.
package cpu5_pkg;

    localparam int CPU_ADDR_W = 3;
    localparam int CPU_DATA_W = 11;
    localparam int CPU_OPC_W  = 7;
    localparam logic [CPU_OPC_W-1:0] CPU_HALT_OPC = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    function automatic logic [CPU_OPC_W-1:0] opc_field(
        input logic [CPU_DATA_W-1:0] word
    );
        return word[CPU_DATA_W-1 -: CPU_OPC_W];
    endfunction

endpackage

// File: rtl/RAM_MxNbit.sv
// M x N-bit register-file RAM: one synchronous write port and two
// asynchronous read ports.
module RAM_MxNbit #(
    parameter int M  = 8,
    parameter int N  = 11,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          Write_Enable,
    input  logic [AW-1:0] Write_Address,
    input  logic [N-1:0]  Write_Data,
    input  logic [AW-1:0] Read_Address_1,
    output logic [N-1:0]  Read_Data_1,
    input  logic [AW-1:0] Read_Address_2,
    output logic [N-1:0]  Read_Data_2
);

    logic [N-1:0] mem [M];

    always_ff @(posedge clk) begin
        if (Write_Enable) begin
            mem[Write_Address] <= Write_Data;
        end
    end

    assign Read_Data_1 = mem[Read_Address_1];
    assign Read_Data_2 = mem[Read_Address_2];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, RAM read address, IR with valid/ready output.
// Optional FETCH_COUNT_EN adds a saturating accepted-instruction counter.
module instr_fetch_unit
    import cpu5_pkg::*;
#(
    parameter int ADDR_W = cpu5_pkg::CPU_ADDR_W,
    parameter int DATA_W = cpu5_pkg::CPU_DATA_W,
    parameter int OPC_W  = cpu5_pkg::CPU_OPC_W,
    parameter logic [OPC_W-1:0] HALT_OPCODE = cpu5_pkg::CPU_HALT_OPC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADDR_W-1:0]       Read_Address,
    input  logic [DATA_W-1:0]       Read_Data,
    input  logic                    redirect,
    input  logic [ADDR_W-1:0]       redirect_target,
    input  logic                    ir_ready,
    output logic                    ir_valid,
    output logic [DATA_W-1:0]       ir,
    output logic [ADDR_W-1:0]       ir_pc,
    output logic [OPC_W-1:0]        opcode,
    output logic [DATA_W-OPC_W-1:0] operand,
    output logic                    halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [7:0]              fetch_count
`endif
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] ir_pc_n;
    logic [DATA_W-1:0] ir_n;
    logic              valid_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            ir_pc    <= ir_pc_n;
            ir_valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        ir_pc_n = ir_pc;
        valid_n = ir_valid;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    pc_n    = '0;
                end
            end
            RUN: begin
                if (redirect) begin
                    pc_n    = redirect_target;
                    valid_n = 1'b0;
                end else if (!ir_valid || ir_ready) begin
                    ir_n    = Read_Data;
                    ir_pc_n = pc;
                    valid_n = 1'b1;
                    // halt word is delivered, but the pc stays on it
                    if (opc_field(Read_Data) == HALT_OPCODE) begin
                        state_n = HALTED;
                    end else begin
                        pc_n = pc + ADDR_W'(1);
                    end
                end
            end
            HALTED: begin
                if (redirect) begin
                    state_n = RUN;
                    pc_n    = redirect_target;
                    valid_n = 1'b0;
                end else if (ir_ready) begin
                    valid_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign Read_Address = pc;
    assign halted       = (state == HALTED);
    assign opcode       = ir[DATA_W-1 -: OPC_W];
    assign operand      = ir[DATA_W-OPC_W-1:0];

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count <= '0;
        end else if (ir_valid && ir_ready && fetch_count != 8'hFF) begin
            fetch_count <= fetch_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit driven from RAM_MxNbit;
// directed scenarios plus a randomized run against a reference model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, start, redirect, ir_ready;
    logic [2:0]  redirect_target;
    logic [2:0]  read_address;
    logic [10:0] read_data;
    logic        ir_valid, halted;
    logic [10:0] ir;
    logic [2:0]  ir_pc;
    logic [6:0]  opcode;
    logic [3:0]  operand;
    logic        we;
    logic [2:0]  waddr;
    logic [10:0] wdata;
    logic [2:0]  ra2;
    logic [10:0] rd2;
`ifdef FETCH_COUNT_EN
    logic [7:0]  fetch_count;
`endif

    logic [10:0] mem [8];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    RAM_MxNbit #(.M(8), .N(11), .AW(3)) u_ram (
        .clk(clk),
        .Write_Enable(we),
        .Write_Address(waddr),
        .Write_Data(wdata),
        .Read_Address_1(read_address),
        .Read_Data_1(read_data),
        .Read_Address_2(ra2),
        .Read_Data_2(rd2)
    );

    instr_fetch_unit dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .Read_Address(read_address),
        .Read_Data(read_data),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .ir_ready(ir_ready),
        .ir_valid(ir_valid),
        .ir(ir),
        .ir_pc(ir_pc),
        .opcode(opcode),
        .operand(operand),
        .halted(halted)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_ram(input int a, input logic [10:0] d);
        we = 1'b1;
        waddr = 3'(a);
        wdata = d;
        mem[a] = d;
        step();
        we = 1'b0;
    endtask

    task automatic load_basic();
        write_ram(0, 11'h001);
        write_ram(1, 11'h603);
        write_ram(2, 11'h004);
        write_ram(3, 11'h7F0);
    endtask

    task automatic load_linear();
        for (int i = 0; i < 8; i++) write_ram(i, 11'(11'h020 + i * 17));
    endtask

    task automatic go();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({ir_valid, halted, read_address, ir, ir_pc} !== 18'h0) begin
            errors++;
            $display("FAIL reset_state got v=%b h=%b pc=%0d ir=%h irpc=%0d exp all zero",
                     ir_valid, halted, read_address, ir, ir_pc);
        end
        reset = 1'b1;
        step();
        step();
        checks++;
        if (ir_valid !== 1'b0 || read_address !== 3'd0) begin
            errors++;
            $display("FAIL idle_no_fetch got v=%b pc=%0d exp v=0 pc=0",
                     ir_valid, read_address);
        end
    endtask

    task automatic test_basic();
        logic [10:0] e [4];
        e = '{11'h001, 11'h603, 11'h004, 11'h7F0};
        load_basic();
        go();
        ir_ready = 1'b1;
        checks++;
        if (ir_valid !== 1'b0 || read_address !== 3'd0) begin
            errors++;
            $display("FAIL start_pc got v=%b pc=%0d exp v=0 pc=0", ir_valid, read_address);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (ir !== e[i] || ir_pc !== 3'(i) || ir_valid !== 1'b1 ||
                opcode !== e[i][10:4] || operand !== e[i][3:0]) begin
                errors++;
                $display("FAIL basic_seq%0d got ir=%h pc=%0d v=%b opc=%h opd=%h exp ir=%h pc=%0d v=1",
                         i, ir, ir_pc, ir_valid, opcode, operand, e[i], i);
            end
        end
        checks++;
        if (halted !== 1'b1 || read_address !== 3'd3) begin
            errors++;
            $display("FAIL halt_enter got h=%b pc=%0d exp h=1 pc=3", halted, read_address);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (halted !== 1'b1 || ir_valid !== 1'b0 || read_address !== 3'd3 || ir !== 11'h7F0) begin
            errors++;
            $display("FAIL halt_hold got h=%b v=%b pc=%0d ir=%h exp h=1 v=0 pc=3 ir=7f0",
                     halted, ir_valid, read_address, ir);
        end
    endtask

    task automatic test_stall();
        load_basic();
        go();
        ir_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ir !== 11'h001 || ir_valid !== 1'b1 || read_address !== 3'd1) begin
                errors++;
                $display("FAIL stall%0d got ir=%h v=%b pc=%0d exp ir=001 v=1 pc=1",
                         i, ir, ir_valid, read_address);
            end
        end
        ir_ready = 1'b1;
        step();
        checks++;
        if (ir !== 11'h603 || ir_pc !== 3'd1 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume got ir=%h pc=%0d v=%b exp ir=603 pc=1 v=1",
                     ir, ir_pc, ir_valid);
        end
    endtask

    task automatic test_wrap();
        load_linear();
        go();
        ir_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (ir_pc !== 3'(i % 8) || ir !== mem[i % 8] || ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL wrap%0d got irpc=%0d ir=%h v=%b exp irpc=%0d ir=%h",
                         i, ir_pc, ir, ir_valid, i % 8, mem[i % 8]);
            end
        end
    endtask

    task automatic test_redirect();
        load_linear();
        go();
        ir_ready = 1'b1;
        step();
        step();
        redirect = 1'b1;
        redirect_target = 3'd5;
        step();
        redirect = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || read_address !== 3'd5) begin
            errors++;
            $display("FAIL redirect_edge got v=%b pc=%0d exp v=0 pc=5", ir_valid, read_address);
        end
        step();
        checks++;
        if (ir !== mem[5] || ir_pc !== 3'd5 || ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_word got ir=%h pc=%0d v=%b exp ir=%h pc=5 v=1",
                     ir, ir_pc, ir_valid, mem[5]);
        end
    endtask

    task automatic test_mid_reset();
        load_linear();
        go();
        ir_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b0;
        redirect = 1'b1;
        redirect_target = 3'd6;
        step();
        reset = 1'b1;
        redirect = 1'b0;
        checks++;
        if ({ir_valid, halted, read_address, ir, ir_pc} !== 18'h0) begin
            errors++;
            $display("FAIL mid_reset got v=%b h=%b pc=%0d ir=%h irpc=%0d exp all zero",
                     ir_valid, halted, read_address, ir, ir_pc);
        end
        step();
        step();
        step();
        checks++;
        if (ir_valid !== 1'b0 || read_address !== 3'd0) begin
            errors++;
            $display("FAIL no_restart got v=%b pc=%0d exp v=0 pc=0", ir_valid, read_address);
        end
    endtask

    task automatic test_random();
        int          mst;
        int          mcnt;
        logic [2:0]  mpc, mirpc, tg;
        logic [10:0] mir, w;
        logic        mval, oldv, rdy, rd;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 7) == 0) w = {7'h7F, 4'($urandom)};
            else w = 11'($urandom_range(0, 11'h7EF));
            write_ram(i, w);
        end
        go();
        mst = 1; mcnt = 0; mpc = 0; mirpc = 0; mir = 0; mval = 0;
        for (int c = 0; c < 500; c++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rd = ($urandom_range(0, 19) == 0);
            tg = 3'($urandom);
            ir_ready = rdy;
            redirect = rd;
            redirect_target = tg;
            start = ($urandom_range(0, 15) == 0);
            step();
            oldv = mval;
            if (oldv && rdy && mcnt < 255) mcnt++;
            if (mst == 1) begin
                if (rd) begin
                    mpc = tg;
                    mval = 0;
                end else if (!oldv || rdy) begin
                    mir = mem[mpc];
                    mirpc = mpc;
                    mval = 1;
                    if (mir[10:4] == 7'h7F) mst = 2;
                    else mpc = mpc + 3'd1;
                end
            end else begin
                if (rd) begin
                    mst = 1;
                    mpc = tg;
                    mval = 0;
                end else if (rdy) begin
                    mval = 0;
                end
            end
            checks++;
            if (ir_valid !== mval || halted !== (mst == 2) || read_address !== mpc ||
                (mval && (ir !== mir || ir_pc !== mirpc))) begin
                errors++;
                $display("FAIL rand%0d got v=%b h=%b pc=%0d ir=%h irpc=%0d exp v=%b h=%b pc=%0d ir=%h irpc=%0d",
                         c, ir_valid, halted, read_address, ir, ir_pc,
                         mval, mst == 2, mpc, mir, mirpc);
            end
`ifdef FETCH_COUNT_EN
            checks++;
            if (fetch_count !== 8'(mcnt)) begin
                errors++;
                $display("FAIL rand_count%0d got %0d exp %0d", c, fetch_count, mcnt);
            end
`endif
        end
        start = 1'b0;
        redirect = 1'b0;
    endtask

`ifdef FETCH_COUNT_EN
    task automatic test_count();
        load_basic();
        go();
        ir_ready = 1'b1;
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (fetch_count !== 8'd4) begin
            errors++;
            $display("FAIL count_halt got %0d exp 4", fetch_count);
        end
        load_linear();
        redirect = 1'b1;
        redirect_target = 3'd0;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 300; i++) step();
        checks++;
        if (fetch_count !== 8'd255) begin
            errors++;
            $display("FAIL count_sat got %0d exp 255", fetch_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        start = 1'b0;
        redirect = 1'b0;
        redirect_target = 3'd0;
        ir_ready = 1'b0;
        we = 1'b0;
        waddr = 3'd0;
        wdata = 11'd0;
        ra2 = 3'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_redirect();
        test_mid_reset();
`ifdef FETCH_COUNT_EN
        test_count();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
